// File: rtl/finv_arbiter.sv
// Two-requester arbiter sharing one pipelined single-precision reciprocal (finv) unit.
// Define FINV_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.

module finv #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic [31:0] src,
    output logic [31:0] dest,
    output logic        ovf,
    output logic        udf
);
    localparam logic [48:0] TWO_48 = 49'h1_0000_0000_0000;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    // q carries one guard bit below the 24-bit significand in q[0]
    function automatic logic [23:0] rnd_ne(input logic [24:0] q, input logic sticky);
        logic inc;
        inc = q[0] & (sticky | q[1]);
        return q[24:1] + {23'd0, inc};
    endfunction

    // Returns {ovf, udf, dest}. Denormal inputs are flushed to zero.
    function automatic logic [33:0] finv_calc(input logic [31:0] a);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [24:0] q;
        logic [23:0] r;
        logic [23:0] mant;
        s    = a[31];
        e    = a[30:23];
        f    = a[22:0];
        q    = 25'(TWO_48 / {25'd0, 1'b1, f});
        r    = 24'(TWO_48 % {25'd0, 1'b1, f});
        mant = rnd_ne(q, r != 24'd0);
        if (e == 8'hFF)
            finv_calc = (f != 23'd0) ? {2'b00, QNAN} : {2'b00, s, 31'd0};
        else if (e == 8'd0)
            finv_calc = {2'b10, s, 8'hFF, 23'd0};
        else if (f == 23'd0)
            finv_calc = (e == 8'd254) ? {2'b01, s, 31'd0}
                                      : {2'b00, s, 8'd254 - e, 23'd0};
        else if (e >= 8'd253)
            finv_calc = {2'b01, s, 31'd0};
        else
            // exponent field is pre-decremented; the hidden bit of mant adds it back
            finv_calc = {2'b00, {s, 8'd252 - e, 23'd0} + {8'd0, mant}};
    endfunction

    logic [LAT-1:0][33:0] res_p1;

    // stage 1..LAT: reciprocal result delay line
    always_ff @(posedge clk) begin
        res_p1[0] <= finv_calc(src);
        for (int i = 1; i < LAT; i++)
            res_p1[i] <= res_p1[i-1];
    end

    assign ovf  = res_p1[LAT-1][33];
    assign udf  = res_p1[LAT-1][32];
    assign dest = res_p1[LAT-1][31:0];
endmodule

module finv_arbiter #(
    parameter int FINV_LAT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid0,
    input  logic        req_valid1,
    input  logic [31:0] req_src0,
    input  logic [31:0] req_src1,
    output logic        req_ready0,
    output logic        req_ready1,
    output logic        res_valid0,
    output logic        res_valid1,
    output logic [31:0] res_data0,
    output logic [31:0] res_data1,
    output logic        res_ovf0,
    output logic        res_udf0,
    output logic        res_ovf1,
    output logic        res_udf1,
    output logic        busy
);
    localparam int DATA_W = 32;

    logic gnt0, gnt1;

`ifdef FINV_ARB_RR_EN
    logic ptr;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rstn) begin
            if (ptr) begin
                gnt1 = req_valid1;
                gnt0 = req_valid0 & ~req_valid1;
            end else begin
                gnt0 = req_valid0;
                gnt1 = req_valid1 & ~req_valid0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            ptr <= 1'b0;
        else if (gnt0)
            ptr <= 1'b1;
        else if (gnt1)
            ptr <= 1'b0;
    end
`else
    always_comb begin
        gnt0 = rstn & req_valid0;
        gnt1 = rstn & req_valid1 & ~req_valid0;
    end
`endif

    assign req_ready0 = gnt0;
    assign req_ready1 = gnt1;

    logic              iss_vld_p0;
    logic [DATA_W-1:0] iss_src_p0;
    logic              iss_tag_p0;

    // stage 0: issue register feeding the finv unit
    always_ff @(posedge clk) begin
        if (!rstn)
            iss_vld_p0 <= 1'b0;
        else
            iss_vld_p0 <= gnt0 | gnt1;
    end

    always_ff @(posedge clk) begin
        if (gnt0 | gnt1) begin
            iss_src_p0 <= gnt1 ? req_src1 : req_src0;
            iss_tag_p0 <= gnt1;
        end
    end

    logic [DATA_W-1:0] fv_dest;
    logic              fv_ovf, fv_udf;

    finv #(.LAT(FINV_LAT)) u_finv (
        .clk  (clk),
        .src  (iss_src_p0),
        .dest (fv_dest),
        .ovf  (fv_ovf),
        .udf  (fv_udf)
    );

    logic [FINV_LAT-1:0] vld_p1;
    logic [FINV_LAT-1:0] tag_p1;

    // stage 1..FINV_LAT: tag/valid shadow of the finv pipeline
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p1 <= '0;
        end else begin
            vld_p1[0] <= iss_vld_p0;
            for (int i = 1; i < FINV_LAT; i++)
                vld_p1[i] <= vld_p1[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_p1[0] <= iss_tag_p0;
        for (int i = 1; i < FINV_LAT; i++)
            tag_p1[i] <= tag_p1[i-1];
    end

    logic              out_vld0_p2, out_vld1_p2;
    logic [DATA_W-1:0] out_data_p2;
    logic              out_ovf_p2, out_udf_p2;

    // stage 2: result register, steered to the owning port by its tag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_vld0_p2 <= 1'b0;
            out_vld1_p2 <= 1'b0;
        end else begin
            out_vld0_p2 <= vld_p1[FINV_LAT-1] & ~tag_p1[FINV_LAT-1];
            out_vld1_p2 <= vld_p1[FINV_LAT-1] &  tag_p1[FINV_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1[FINV_LAT-1]) begin
            out_data_p2 <= fv_dest;
            out_ovf_p2  <= fv_ovf;
            out_udf_p2  <= fv_udf;
        end
    end

    logic rv0, rv1;
    assign rv0 = rstn & out_vld0_p2;
    assign rv1 = rstn & out_vld1_p2;

    assign res_valid0 = rv0;
    assign res_valid1 = rv1;
    assign res_data0  = rv0 ? out_data_p2 : '0;
    assign res_data1  = rv1 ? out_data_p2 : '0;
    assign res_ovf0   = rv0 & out_ovf_p2;
    assign res_udf0   = rv0 & out_udf_p2;
    assign res_ovf1   = rv1 & out_ovf_p2;
    assign res_udf1   = rv1 & out_udf_p2;

    assign busy = rstn & (iss_vld_p0 | (|vld_p1) | out_vld0_p2 | out_vld1_p2);
endmodule

// File: doc/finv_arbiter.md
FINV_ARBITER -- requirements
Module: finv_arbiter

Interface
REQ-001 SHALL have parameter FINV_LAT, default 2, meaning clock cycles from finv src capture to valid dest/ovf/udf.
REQ-002 SHALL have port clk  input  1  the only clock, all state on rising edge.
REQ-003 SHALL have port rstn  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports req_valid0, req_valid1  input  1 each  requester k presents an operand.
REQ-005 SHALL have ports req_src0, req_src1  input  32 each  IEEE-754 single operand for requester k.
REQ-006 SHALL have ports req_ready0, req_ready1  output  1 each  requester k is granted this cycle.
REQ-007 SHALL have ports res_valid0, res_valid1  output  1 each  one-cycle pulse, result for requester k.
REQ-008 SHALL have ports res_data0, res_data1  output  32 each  1/src result.
REQ-009 SHALL have ports res_ovf0, res_udf0, res_ovf1, res_udf1  output  1 each  finv flags for that result.
REQ-010 SHALL have port busy  output  1  high while any accepted operation has not yet been returned.

Function
REQ-011 SHALL instantiate exactly one finv unit and share it between both requesters.
REQ-012 SHALL accept at most one request per cycle; a transfer occurs on a rising edge where req_validk and req_readyk are both high.
REQ-013 req_readyk SHALL be combinational from req_valid0/1 and arbiter state; at most one req_ready high per cycle; req_readyk low when req_validk low.
REQ-014 SHALL grant whenever any request is valid (no idle cycle while requests pend); full throughput one issue per cycle.
REQ-015 Accepted operand SHALL be registered into an issue register (valid bit, operand, 1-bit tag) driving finv src.
REQ-016 Tag/valid SHALL travel in a shift pipeline of depth FINV_LAT aligned with finv.
REQ-017 Request accepted at edge N SHALL yield res_validk high for exactly the cycle after edge N+1+FINV_LAT (3 cycles after acceptance for default), with res_datak/ovfk/udfk equal to finv dest/ovf/udf for that operand.
REQ-018 Results SHALL return in acceptance order; no result backpressure; res_valid never high for both ports in one cycle.
REQ-019 res_datak/flags SHALL be 0 whenever res_validk is low.
REQ-020 busy SHALL be high in every cycle from the cycle after an acceptance until the cycle its result pulse is driven, inclusive; low otherwise.
REQ-021 Requester whose req_valid drops without grant SHALL lose nothing (no implicit queueing).

Reset
REQ-022 With rstn low at a rising edge: issue valid, all pipeline valid bits, priority pointer cleared to 0 (port 0 preferred).
REQ-023 During and after reset edge: req_ready0/1 SHALL be 0 while rstn low; res_valid0/1=0, res_data/flags=0, busy=0.
REQ-024 Reset mid-operation SHALL discard all in-flight operations; no res_valid pulse for them after rstn returns high.
REQ-025 First acceptance SHALL be possible in the first cycle with rstn high.

Configuration
REQ-026 Macro FINV_ARB_RR_EN defined: round-robin; pointer moves to the other port after each grant; on simultaneous valid, the pointer port wins.
REQ-027 FINV_ARB_RR_EN undefined: fixed priority, port 0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-028 Single: port0 src 0x40000000 at edge N -> res_valid0 one cycle after edge N+3, res_data0 0x3F000000, flags 0; busy high meanwhile.
REQ-029 Contention after reset, both valid continuously, port0 0x40800000, port1 0x3F800000 -> grants alternate 0,1,0,1 with RR_EN; results 0x3E800000 / 0x3F800000 on matching ports, one per cycle, in order.
REQ-030 Same stimulus without FINV_ARB_RR_EN -> port1 never granted while port0 valid; port1 granted first cycle port0 drops.
REQ-031 Back-to-back port1 0x40000000, 0x40800000, 0x3F800000 over 3 cycles -> three consecutive res_valid1 pulses 0x3F000000, 0x3E800000, 0x3F800000.
REQ-032 Accept two ops then rstn low one edge -> no res_valid ever for them; busy 0; next op after release returns normally.
REQ-033 Port0 src 0x00000001 -> res_ovf0/res_udf0 bit-identical to finv ovf/udf for that input, res_valid1 stays 0.
